// File: rtl/am_tx_1b_pkg.sv
// Shared types and defaults for the 1-bit AM transmitter.
package am_tx_1b_pkg;

  localparam int PHASE_BITS_DEF  = 26;
  localparam int SAMPLE_BITS_DEF = 16;
  localparam int FULL_SCALE      = 2 ** SAMPLE_BITS_DEF;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RAMP_UP = 2'd1,
    ST_RUN     = 2'd2,
    ST_RAMP_DN = 2'd3
  } tx_state_t;

endpackage

// File: rtl/ds_mod_1b.sv
// First-order delta-sigma modulator: signed level in, one bit plus its complement out.
module ds_mod_1b #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                RSTb,
  input  logic                en,
  input  logic signed [W+1:0] v,
  output logic                q,
  output logic                q_n
);

  localparam logic signed [W+1:0] FS = {2'b01, {W{1'b0}}};

  logic signed [W+1:0] err;
  logic signed [W+2:0] sum;

  assign sum = {err[W+1], err} + {v[W+1], v};

  // Feedback of +/-FS keeps err inside +/-FS, so the 18-bit truncation is exact.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      err <= '0;
      q   <= 1'b0;
      q_n <= 1'b1;
    end else if (!en) begin
      err <= '0;
      q   <= 1'b0;
      q_n <= 1'b1;
    end else begin
      q   <= !sum[W+2];
      q_n <= sum[W+2];
      err <= sum[W+2] ? sum[W+1:0] + FS : sum[W+1:0] - FS;
    end
  end

endmodule

// File: rtl/am_tx_1b.sv
// 1-bit AM transmitter: audio-scaled envelope, square carrier, delta-sigma RF pin with soft ramps.
module am_tx_1b
  import am_tx_1b_pkg::*;
#(
  parameter int PHASE_BITS  = PHASE_BITS_DEF,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int RAMP_STEP   = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic                          clk,
  input  logic                          RSTb,
  input  logic                          tx_en,
  input  logic        [PHASE_BITS-1:0]  phase_inc,
  input  logic        [SAMPLE_BITS-1:0] carrier_level,
  input  logic        [7:0]             mod_depth,
  input  logic signed [SAMPLE_BITS-1:0] audio_in,
  input  logic                          in_tick,
  output logic                          RF_OUT,
  output logic                          RF_OUT_N,
  output logic                          busy,
  output logic                          underrun
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = SAMPLE_BITS + 9;

  logic        [PHASE_BITS-1:0]  acc;
  logic                          carrier_sq;
  logic signed [SAMPLE_BITS-1:0] samp;
  logic        [SAMPLE_BITS-1:0] target;
  logic        [SAMPLE_BITS-1:0] target_nxt;
  logic        [SAMPLE_BITS-1:0] env_cur;
  logic        [TW-1:0]          to_cnt;
  tx_state_t                     state;

  logic signed [PW-1:0]          prod;
  logic signed [SAMPLE_BITS+1:0] mod_sum;
  logic                          to_hit;
  logic        [SAMPLE_BITS:0]   env_up;
  logic        [SAMPLE_BITS-1:0] up_val;
  logic                          up_reach;
  logic                          env_low;
  logic        [SAMPLE_BITS-1:0] dn_val;
  logic        [SAMPLE_BITS-1:0] ds_env;
  logic signed [SAMPLE_BITS+1:0] ds_v;

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) acc <= '0;
    else       acc <= acc + phase_inc;
  end

  assign carrier_sq = acc[PHASE_BITS-1];

  assign prod    = PW'(samp) * PW'($signed({1'b0, mod_depth}));
  assign mod_sum = $signed({2'b00, carrier_level}) + (SAMPLE_BITS+2)'(prod >>> 8);

  always_comb begin
    target_nxt = mod_sum[SAMPLE_BITS-1:0];
    if (mod_sum[SAMPLE_BITS+1])    target_nxt = '0;
    else if (mod_sum[SAMPLE_BITS]) target_nxt = '1;
  end

  // A tick on the same clock as the timeout hit wins, so no underrun is flagged.
  assign to_hit = (state == ST_RUN) && !in_tick && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      samp     <= '0;
      to_cnt   <= '0;
      underrun <= 1'b0;
      target   <= '0;
    end else begin
      target <= target_nxt;
      if (in_tick) begin
        samp     <= audio_in;
        to_cnt   <= '0;
        underrun <= 1'b0;
      end else if (to_hit) begin
        samp     <= '0;
        to_cnt   <= TW'(TIMEOUT);
        underrun <= 1'b1;
      end else if (state == ST_RUN && to_cnt != TW'(TIMEOUT)) begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  assign env_up   = {1'b0, env_cur} + (SAMPLE_BITS+1)'(RAMP_STEP);
  assign up_reach = env_up >= {1'b0, target};
  assign up_val   = up_reach ? target : env_up[SAMPLE_BITS-1:0];
  assign env_low  = env_cur <= SAMPLE_BITS'(RAMP_STEP);
  assign dn_val   = env_low ? '0 : env_cur - SAMPLE_BITS'(RAMP_STEP);

  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      state   <= ST_OFF;
      env_cur <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          env_cur <= '0;
          if (tx_en) begin
            state <= ST_RAMP_UP;
            busy  <= 1'b1;
          end
        end
        ST_RAMP_UP: begin
          if (!tx_en) begin
            env_cur <= dn_val;
            state   <= env_low ? ST_OFF : ST_RAMP_DN;
            busy    <= !env_low;
          end else begin
            env_cur <= up_val;
            if (up_reach) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!tx_en) begin
            env_cur <= dn_val;
            state   <= env_low ? ST_OFF : ST_RAMP_DN;
            busy    <= !env_low;
          end else begin
            env_cur <= target;
          end
        end
        ST_RAMP_DN: begin
          if (tx_en) begin
            env_cur <= up_val;
            state   <= ST_RAMP_UP;
          end else begin
            env_cur <= dn_val;
            state   <= env_low ? ST_OFF : ST_RAMP_DN;
            busy    <= !env_low;
          end
        end
        default: begin
          state   <= ST_OFF;
          env_cur <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // In RUN the modulator follows target directly so a new sample reaches the pin one clock sooner.
  assign ds_env = (state == ST_RUN) ? target : env_cur;
  assign ds_v   = carrier_sq ? $signed({2'b00, ds_env}) : -$signed({2'b00, ds_env});

  ds_mod_1b #(.W(SAMPLE_BITS)) u_ds (
    .clk (clk),
    .RSTb(RSTb),
    .en  (state != ST_OFF),
    .v   (ds_v),
    .q   (RF_OUT),
    .q_n (RF_OUT_N)
  );

endmodule

// File: tb/tb_am_tx_1b.sv
// Self-checking bench for am_tx_1b: directed ramp/underrun/reset steps plus randomized modulation cases.
module tb_am_tx_1b;

  logic        clk = 1'b0;
  logic        RSTb = 1'b0;
  logic        tx_en = 1'b0;
  logic        in_tick = 1'b0;
  logic [25:0] phase_inc = 26'h001_0000;
  logic [15:0] carrier_level = 16'h8000;
  logic [15:0] audio_in = 16'h0000;
  logic [7:0]  mod_depth = 8'd0;
  logic        RF_OUT, RF_OUT_N, busy, underrun;

  int checks = 0;
  int failures = 0;

  logic [25:0] acc_m = '0;
  logic        cs_used = 1'b0;

  int c_car[11], c_dep[11], c_aud[11], c_pinc[11];

  am_tx_1b dut (
    .clk          (clk),
    .RSTb         (RSTb),
    .tx_en        (tx_en),
    .phase_inc    (phase_inc),
    .carrier_level(carrier_level),
    .mod_depth    (mod_depth),
    .audio_in     (audio_in),
    .in_tick      (in_tick),
    .RF_OUT       (RF_OUT),
    .RF_OUT_N     (RF_OUT_N),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Independent NCO model: cs_used is the carrier polarity that drove the RF bit now on the pin.
  always @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      acc_m   <= '0;
      cs_used <= 1'b0;
    end else begin
      cs_used <= acc_m[25];
      acc_m   <= acc_m + phase_inc;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int ref_env(input int carrier, input int depth, input int audio_s);
    int p, q, s;
    p = audio_s * depth;
    q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    s = carrier + q;
    if (s < 0) return 0;
    if (s > 65535) return 65535;
    return s;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [15:0] a);
    audio_in = a;
    in_tick  = 1'b1;
    step();
    in_tick  = 1'b0;
  endtask

  // Over any window with a constant envelope, sum(v) - sum(+/-FS) equals the change in the bounded error.
  task automatic measure(input string tag, input int env, input int cycles, output int ones);
    longint sv, sd, sdn, d1, d2;
    sv = 0; sd = 0; sdn = 0; ones = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      sv   += cs_used ? env : -env;
      sd   += RF_OUT ? 65536 : -65536;
      sdn  += RF_OUT_N ? -65536 : 65536;
      ones += int'(RF_OUT);
    end
    d1 = sv - sd;
    d2 = sv - sdn;
    check({tag, "_rf"},  (d1 <= 131071 && d1 >= -131071) ? 0 : d1, 0);
    check({tag, "_rfn"}, (d2 <= 131071 && d2 >= -131071) ? 0 : d2, 0);
  endtask

  task automatic measure_halves(input int exp_hi, input int exp_lo);
    int hi, lo, guard;
    hi = 0; lo = 0; guard = 0;
    do begin step(); guard++; end while (cs_used !== 1'b0 && guard < 4000);
    do begin step(); guard++; end while (cs_used !== 1'b1 && guard < 4000);
    hi = int'(RF_OUT);
    while (guard < 4000) begin
      step(); guard++;
      if (cs_used !== 1'b1) break;
      hi += int'(RF_OUT);
    end
    lo = int'(RF_OUT);
    while (guard < 4000) begin
      step(); guard++;
      if (cs_used !== 1'b0) break;
      lo += int'(RF_OUT);
    end
    check("halves_bound", (guard < 4000) ? 0 : guard, 0);
    check("half_hi_ones", (hi >= exp_hi - 1 && hi <= exp_hi + 1) ? exp_hi : hi, exp_hi);
    check("half_lo_ones", (lo >= exp_lo - 1 && lo <= exp_lo + 1) ? exp_lo : lo, exp_lo);
  endtask

  task automatic off_time(input string tag, input int exp_n);
    int n;
    tx_en = 1'b0;
    n = 0;
    do begin step(); n++; end while (busy !== 1'b0 && n < 5000);
    check(tag, n, exp_n);
  endtask

  task automatic run_case(input int i, output int e);
    logic [15:0] a16;
    int ones;
    a16           = c_aud[i][15:0];
    phase_inc     = c_pinc[i][25:0];
    carrier_level = c_car[i][15:0];
    mod_depth     = c_dep[i][7:0];
    tick(a16);
    repeat (3) step();
    e = ref_env(c_car[i], c_dep[i], int'($signed(a16)));
    measure($sformatf("mod%0d", i), e, 512, ones);
    if (c_pinc[i] == (1 << 25)) begin
      measure($sformatf("wrap%0d", i), e, 64, ones);
      check($sformatf("wrap%0d_ones", i), (ones >= 31 && ones <= 33) ? 32 : ones, 32);
    end
  endtask

  initial begin
    int ones, e;

    // Reset state
    repeat (3) step();
    check("rst_rf", RF_OUT, 0);
    check("rst_rfn", RF_OUT_N, 1);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    RSTb = 1'b1;
    repeat (10) step();
    check("off_idle_busy", busy, 0);

    // Steady carrier, ramp up to RUN, per-half ones density, ramp down
    tick(16'h0000);
    tx_en = 1'b1;
    repeat (2049) step();
    check("run_busy", busy, 1);
    measure_halves(384, 128);
    measure("steady", 32768, 512, ones);
    off_time("rampdn_full", 2048);

    // Reversal mid-ramp in both directions
    tick(16'h0000);
    tx_en = 1'b1;
    repeat (1000) step();
    off_time("rev_up_dn", 999);
    tx_en = 1'b1;
    repeat (2049) step();
    tx_en = 1'b0;
    repeat (500) step();
    tx_en = 1'b1;
    repeat (200) step();
    off_time("rev_dn_up", 2048 - 500 + 200);

    // Modulation: directed clamp/wrap cases then random cases
    c_car[0] = 32'h8000; c_dep[0] = 128; c_aud[0] = 32'h4000; c_pinc[0] = 1 << 16;
    c_car[1] = 32'h1000; c_dep[1] = 255; c_aud[1] = 32'h8000; c_pinc[1] = 1 << 16;
    c_car[2] = 32'hF000; c_dep[2] = 255; c_aud[2] = 32'h7FFF; c_pinc[2] = 1 << 16;
    c_car[3] = 32'hFFFF; c_dep[3] = 0;   c_aud[3] = 0;        c_pinc[3] = 1 << 25;
    c_car[4] = 32'h3000; c_dep[4] = 200; c_aud[4] = 32'h1234; c_pinc[4] = 1 << 25;
    for (int i = 5; i < 11; i++) begin
      c_car[i]  = int'($urandom_range(0, 65535));
      c_dep[i]  = int'($urandom_range(0, 255));
      c_aud[i]  = int'($urandom_range(0, 65535));
      c_pinc[i] = int'($urandom_range(1, 1 << 25));
    end
    carrier_level = 16'h8000;
    mod_depth     = 8'd0;
    phase_inc     = 26'h001_0000;
    tick(16'h0000);
    tx_en = 1'b1;
    repeat (2060) step();
    e = 0;
    for (int i = 0; i < 11; i++) run_case(i, e);
    off_time("rampdn_last", (e == 0) ? 1 : (e + 15) / 16);

    // Underrun: timeout, recovery, tick landing on the timeout clock
    carrier_level = 16'h8000;
    mod_depth     = 8'd128;
    phase_inc     = 26'h001_0000;
    tick(16'h4000);
    tx_en = 1'b1;
    repeat (2570) step();
    tick(16'h4000);
    repeat (4095) step();
    check("ur_before", underrun, 0);
    step();
    check("ur_hit", underrun, 1);
    repeat (3) step();
    measure("ur_carrier_only", 32768, 512, ones);
    tick(16'h1000);
    check("ur_clear", underrun, 0);
    repeat (3) step();
    measure("ur_recover", 32768 + 2048, 512, ones);
    tick(16'h1000);
    repeat (4095) step();
    tick(16'h1000);
    check("ur_tick_wins", underrun, 0);
    repeat (4095) step();
    check("ur_before2", underrun, 0);
    step();
    check("ur_hit2", underrun, 1);

    // Asynchronous reset mid-RUN, then stay OFF without tx_en
    RSTb = 1'b0;
    #2;
    check("arst_rf", RF_OUT, 0);
    check("arst_rfn", RF_OUT_N, 1);
    check("arst_busy", busy, 0);
    check("arst_underrun", underrun, 0);
    step();
    tx_en = 1'b0;
    RSTb  = 1'b1;
    ones  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ones += int'(RF_OUT);
    end
    check("post_rst_busy", busy, 0);
    check("post_rst_rf_ones", ones, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
